cp0_int: RTL and testbench
==========================

Name: cp0_int

Overview:
- MIPS coprocessor-0 block: the CPU-side receiver of the device interrupt lines (timer IRQ on HWInt[2], others reserved).
- Holds SR, Cause, EPC and PRId. Raises IntReq to the pipeline control when an enabled interrupt is pending.
- Saves the return PC on interrupt entry and serves mfc0/mtc0/eret.
- Sits inside the mips top, between the controller/datapath and the external HWInt[7:2] pins.

Parameters:
- PRID, 32'h0000_0C05, constant value returned by PRId (reg 15).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- PC  in  30  word address of the instruction to resume (PC[31:2])
- DIn  in  32  mtc0 write data (GPR rt)
- HWInt  in  6  hardware interrupt lines [7:2], level-sensitive, active-high
- Sel  in  5  CP0 register number for read/write (rd field)
- Wen  in  1  mtc0 write enable
- EXLSet  in  1  interrupt entry strobe from controller (1 cycle)
- EXLClr  in  1  eret strobe from controller (1 cycle)
- IntReq  out  1  interrupt request to controller
- EPC  out  30  saved resume address [31:2]
- DOut  out  32  mfc0 read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All registers update on the rising edge of clk only.
- Register map:
  - SR (12): IM=[15:10], EXL=[1], IE=[0]. Other bits read 0 and are not stored.
  - Cause (13): IP=[15:10]. Other bits read 0. Read-only.
  - EPC (14): bits [31:2] stored; [1:0] read 0.
  - PRId (15): read-only, returns PRID.
  - Any other Sel reads 32'h0; writes to it are ignored.
- Reset (rst=1 at an edge): IM=0, EXL=0, IE=0, IP=0, EPC=0. Therefore IntReq=0 and EPC=0 immediately after reset. Reset overrides every other input in that cycle, including EXLSet.
- IP: IP<=HWInt every cycle; it is a 1-cycle-delayed view of the lines, used for reads only.
- IntReq: combinational, IntReq = (|(HWInt & IM)) & IE & ~EXL. It is driven from live HWInt, not IP, so there is zero latency from line to request. IntReq deasserts in the same cycle the line drops or the mask clears.
- mtc0 (Wen=1):
  - Sel=12: IM<=DIn[15:10], EXL<=DIn[1], IE<=DIn[0].
  - Sel=14: EPC<=DIn[31:2].
  - Other Sel: no effect.
- Interrupt entry (EXLSet=1): EXL<=1 and EPC<=PC at the edge. IntReq falls the next cycle even if the line stays high.
- eret (EXLClr=1): EXL<=0. If the line is still high and enabled, IntReq rises again the following cycle (re-entry is legal, level semantics).
- Priority for simultaneous events in one cycle:
  - EXLSet > EXLClr > Wen for the EXL bit.
  - EXLSet > Wen for EPC.
  - IM and IE still take an mtc0 SR write even when EXLSet is active.
- DOut: combinational mux on Sel, reflecting register contents before the current edge. A read and a write to the same register in one cycle returns the old value.
- HWInt is assumed synchronous to clk (timer is on the same clock); no synchronizer is included.

Test Plan:
- Reset: hold rst=1 for 2 cycles with HWInt=6'h3F and Wen=1 -> IntReq=0, EPC=0, DOut for Sel=12/13/14 = 0, Sel=15 = 32'h0000_0C05.
- Enable and fire: mtc0 SR=32'h0000_0401 (IM[2]=1, IE=1), then HWInt[2]=1 -> IntReq=1 in the same cycle; one cycle later mfc0 Cause = 32'h0000_0400. HWInt=6'h02 with IM=6'h01 -> IntReq=0.
- Entry/exit: with IntReq=1, pulse EXLSet with PC=30'h0000_0C03 -> next cycle EXL=1, IntReq=0, EPC=30'h0000_0C03, mfc0 Sel=14 = 32'h0000_300C. Pulse EXLClr with HWInt[2] still high -> IntReq=1 the next cycle.
- Masking: IE=0 or EXL=1 with HWInt[2]=1 and IM[2]=1 -> IntReq stays 0. mtc0 SR DIn=32'hFFFF_FFFF -> mfc0 SR = 32'h0000_FC03.
- Collisions:
  - Same cycle EXLSet=1, Wen=1, Sel=14, DIn=32'h1234_5678, PC=30'h100 -> EPC=30'h100.
  - EXLSet and EXLClr together -> EXL=1.
  - Wen Sel=12 DIn=0 together with EXLSet -> IM=0, IE=0, EXL=1.
- Read-only and unmapped: mtc0 to Sel=13, 15 and 7 -> Cause, PRId and reg 7 unchanged; mfc0 Sel=7 = 0.

Source files
------------

// File: rtl/cp0_int.sv
// cp0_int - MIPS coprocessor-0 interrupt block.
//
// Receives the device interrupt lines HWInt[7:2] and holds SR, Cause, EPC
// and PRId. It raises IntReq when an enabled line is pending. It saves the
// resume PC on interrupt entry and serves mfc0/mtc0/eret.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous reset, active-high
//   PC      in  30  resume word address (PC[31:2])
//   DIn     in  32  mtc0 write data
//   HWInt   in   6  interrupt lines [7:2], level-sensitive, active-high
//   Sel     in   5  CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   Wen     in   1  mtc0 write enable
//   EXLSet  in   1  interrupt entry strobe
//   EXLClr  in   1  eret strobe
//   IntReq  out  1  interrupt request to the controller
//   EPC     out 30  saved resume address [31:2]
//   DOut    out 32  mfc0 read data (pre-edge register contents)
module cp0_int #(
  parameter logic [31:0] PRID = 32'h0000_0C05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] PC,
  input  logic [31:0] DIn,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  Sel,
  input  logic        Wen,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [29:0] r_epc;

  logic w_sr_wr;
  logic w_epc_wr;

  assign w_sr_wr  = Wen && (Sel == SEL_SR);
  assign w_epc_wr = Wen && (Sel == SEL_EPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_ip  <= 6'd0;
      r_epc <= 30'd0;
    end else begin
      // Cause.IP is only a delayed view of the lines, used for reads.
      r_ip <= HWInt;

      // IM/IE follow an SR write even during interrupt entry.
      if (w_sr_wr) begin
        r_im <= DIn[15:10];
        r_ie <= DIn[0];
      end

      // Entry wins over eret, which wins over a software write.
      if (EXLSet) begin
        r_exl <= 1'b1;
      end else if (EXLClr) begin
        r_exl <= 1'b0;
      end else if (w_sr_wr) begin
        r_exl <= DIn[1];
      end

      // The hardware-saved PC wins over an mtc0 to EPC in the same cycle.
      if (EXLSet) begin
        r_epc <= PC;
      end else if (w_epc_wr) begin
        r_epc <= DIn[31:2];
      end
    end
  end

  // Uses live HWInt rather than IP so a line reaches the pipeline with no delay.
  assign IntReq = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign EPC    = r_epc;

  always_comb begin
    DOut = 32'h0;
    case (Sel)
      SEL_SR:    DOut = {16'h0, r_im, 8'h0, r_exl, r_ie};
      SEL_CAUSE: DOut = {16'h0, r_ip, 10'h0};
      SEL_EPC:   DOut = {r_epc, 2'b00};
      SEL_PRID:  DOut = PRID;
      default:   DOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int.sv
module tb_cp0_int;

  logic        clk;
  logic        rst;
  logic [29:0] PC;
  logic [31:0] DIn;
  logic [5:0]  HWInt;
  logic [4:0]  Sel;
  logic        Wen;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain integers, packed into registers only on read.
  int m_im, m_exl, m_ie, m_ip, m_epc;

  cp0_int dut (
    .clk    (clk),
    .rst    (rst),
    .PC     (PC),
    .DIn    (DIn),
    .HWInt  (HWInt),
    .Sel    (Sel),
    .Wen    (Wen),
    .EXLSet (EXLSet),
    .EXLClr (EXLClr),
    .IntReq (IntReq),
    .EPC    (EPC),
    .DOut   (DOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int s);
    case (s)
      12: return 32'((m_im * 1024) + (m_exl * 2) + m_ie);
      13: return 32'(m_ip * 1024);
      14: return 32'(m_epc) * 32'd4;
      15: return 32'h0000_0C05;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq(input int hw);
    return ((hw & m_im) != 0) && (m_ie == 1) && (m_exl == 0);
  endfunction

  task automatic model_edge();
    int srw, epcw, d;
    d = int'(DIn);
    if (rst) begin
      m_im = 0; m_exl = 0; m_ie = 0; m_ip = 0; m_epc = 0;
      return;
    end
    srw  = (Wen && Sel == 5'd12) ? 1 : 0;
    epcw = (Wen && Sel == 5'd14) ? 1 : 0;
    m_ip = int'(HWInt);
    if (EXLSet)       m_exl = 1;
    else if (EXLClr)  m_exl = 0;
    else if (srw != 0) m_exl = (d >> 1) & 1;
    if (srw != 0) begin
      m_im = (d >> 10) & 63;
      m_ie = d & 1;
    end
    if (EXLSet)        m_epc = int'(PC);
    else if (epcw != 0) m_epc = int'(DIn >> 2);
  endtask

  // One clock: drive inputs, check the pre-edge outputs, advance the model.
  task automatic cycle(input logic r, input logic [29:0] pc, input logic [31:0] din,
                       input logic [5:0] hw, input logic [4:0] s, input logic w,
                       input logic set, input logic clr, input bit chk);
    rst = r; PC = pc; DIn = din; HWInt = hw; Sel = s; Wen = w; EXLSet = set; EXLClr = clr;
    #1;
    if (chk) begin
      check("cyc_intreq", {31'd0, IntReq}, {31'd0, model_irq(int'(hw))});
      check("cyc_dout", DOut, model_read(int'(s)));
      check("cyc_epc", {2'b00, EPC}, 32'(m_epc));
    end
    @(posedge clk);
    model_edge();
    $display("[TB] t=%0t rst=%0b pc=%h din=%h hw=%h sel=%0d wen=%0b set=%0b clr=%0b irq=%0b dout=%h",
             $time, r, pc, din, hw, s, w, set, clr, IntReq, DOut);
    @(negedge clk);
  endtask

  // Mid-cycle read with no write side effects; stays well before the next edge.
  task automatic peek_dout(input logic [4:0] s, input logic [31:0] exp, input string tag);
    Sel = s; Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0; rst = 1'b0;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic peek_irq(input logic exp, input string tag);
    #1;
    check(tag, {31'd0, IntReq}, {31'd0, exp});
  endtask

  task automatic peek_epc(input logic [29:0] exp, input string tag);
    #1;
    check(tag, {2'b00, EPC}, {2'b00, exp});
  endtask

  initial begin
    int r, s, sel_pick;
    m_im = 0; m_exl = 0; m_ie = 0; m_ip = 0; m_epc = 0;
    rst = 1'b1; PC = '0; DIn = '0; HWInt = '0; Sel = '0; Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;

    // Reset held two cycles while lines and a write are active.
    cycle(1'b1, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 6'h3F, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 6'h3F, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
    peek_irq(1'b0, "rst_intreq");
    peek_epc(30'h0, "rst_epc");
    peek_dout(5'd12, 32'h0, "rst_sr");
    peek_dout(5'd13, 32'h0, "rst_cause");
    peek_dout(5'd14, 32'h0, "rst_epc_rd");
    peek_dout(5'd15, 32'h0000_0C05, "rst_prid");

    // Enable and fire.
    cycle(1'b0, 30'h0, 32'h0000_0401, 6'h00, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 30'h0, 32'h0, 6'h01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    peek_irq(1'b1, "fire_intreq");
    peek_dout(5'd13, 32'h0000_0400, "fire_cause");
    cycle(1'b0, 30'h0, 32'h0000_0401, 6'h02, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    peek_irq(1'b0, "unmasked_line");

    // Entry and eret.
    cycle(1'b0, 30'h0, 32'h0, 6'h01, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 30'h0000_0C03, 32'h0, 6'h01, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
    peek_irq(1'b0, "entry_intreq");
    peek_epc(30'h0000_0C03, "entry_epc");
    peek_dout(5'd14, 32'h0000_300C, "entry_epc_rd");
    peek_dout(5'd12, 32'h0000_0403, "entry_sr");
    cycle(1'b0, 30'h0, 32'h0, 6'h01, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
    peek_irq(1'b1, "eret_reentry");

    // Masking.
    cycle(1'b0, 30'h0, 32'h0000_0400, 6'h01, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    peek_irq(1'b0, "mask_ie0");
    cycle(1'b0, 30'h0, 32'h0000_0403, 6'h01, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    peek_irq(1'b0, "mask_exl1");
    cycle(1'b0, 30'h0, 32'hFFFF_FFFF, 6'h01, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    peek_dout(5'd12, 32'h0000_FC03, "sr_all_ones");

    // Collisions.
    cycle(1'b0, 30'h100, 32'h1234_5678, 6'h01, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1);
    peek_epc(30'h100, "coll_epc");
    cycle(1'b0, 30'h0, 32'h0000_0401, 6'h01, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 30'h55, 32'h0, 6'h01, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1);
    peek_dout(5'd12, 32'h0000_0403, "coll_set_clr");
    cycle(1'b0, 30'h66, 32'h0, 6'h01, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
    peek_dout(5'd12, 32'h0000_0002, "coll_sr_set");

    // Read-only and unmapped writes.
    cycle(1'b0, 30'h0, 32'hFFFF_FFFF, 6'h05, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 30'h0, 32'h0, 6'h05, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 30'h0, 32'hFFFF_FFFF, 6'h05, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    peek_dout(5'd7, 32'h0, "unmapped_rd");
    peek_dout(5'd15, 32'h0000_0C05, "prid_ro");
    peek_dout(5'd13, 32'h0000_1400, "cause_ro");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      sel_pick = $urandom_range(0, 5);
      case (sel_pick)
        0: s = 12; 1: s = 12; 2: s = 13; 3: s = 14; 4: s = 15;
        default: s = $urandom_range(0, 31);
      endcase
      cycle(($urandom_range(0, 49) == 0), 30'($urandom), $urandom, 6'($urandom),
            5'(s), (r < 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
